ternary_requant_packer: RTL

Output side of a ternary layer: takes the signed 7-bit accumulator results produced by the ternary MAC array, one neuron per transfer. Each result is requantized to a 2-bit unsigned activation [0-3] via ReLU, arithmetic right shift and clamp. Four activations are packed into a byte so the next layer's MACs can read them back as 2-bit `input_val` operands. Input and output are valid/ready streams; the block also keeps a saturation counter for calibration.

---
 rtl/ternary_requant_packer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ternary_requant_packer.sv
// ternary_requant_packer
// Output stage of a ternary layer. Each signed 7-bit accumulator result is
// requantized to a 2-bit activation (ReLU, arithmetic shift, clamp to 3), and
// four activations are packed per byte for the next layer. Input and output
// are valid/ready streams with a single-entry output register. A saturating
// counter records how many inputs were clamped, for calibration.

module ternary_requant_packer #(
  parameter int SHIFT = 2  // right shift applied after ReLU, legal range 0-6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] acc_in,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] out_lanes,
  output logic       out_last,
  output logic [7:0] sat_cnt
);

  // Activation datapath signals.
  logic       acc_neg;
  logic [5:0] acc_mag;
  logic [5:0] acc_shifted;
  logic       sat_event;
  logic [1:0] act;

  // Handshake and control decode.
  logic       accept;
  logic       emit;
  logic       store;
  logic       out_drain;

  // Byte assembled from the buffered lanes plus the current activation.
  logic [7:0] pack_byte;
  logic [2:0] act_pos;

  // Architectural state.
  logic [1:0] lane_d [3];
  logic [1:0] lane_q [3];
  logic [1:0] cnt_d, cnt_q;
  logic       out_valid_d, out_valid_q;
  logic [7:0] out_data_d, out_data_q;
  logic [2:0] out_lanes_d, out_lanes_q;
  logic       out_last_d, out_last_q;
  logic [7:0] sat_cnt_d, sat_cnt_q;

  // Requantize: negative inputs map to 0; non-negative inputs are shifted
  // and clamped to 3. Only a non-negative value above 3 counts as saturation.
  always_comb begin
    acc_neg     = acc_in[6];
    acc_mag     = acc_in[5:0];
    acc_shifted = acc_mag >> SHIFT;
    sat_event   = !acc_neg && (acc_shifted > 6'd3);
    if (acc_neg) begin
      act = 2'd0;
    end else if (sat_event) begin
      act = 2'd3;
    end else begin
      act = acc_shifted[1:0];
    end
  end

  // Stream handshake. in_ready is the only combinational output: it stalls the
  // input whenever the output register is full and not being drained, even
  // mid-byte, and while a synchronous clear is in progress.
  always_comb begin
    in_ready  = !clr && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    emit      = accept && ((cnt_q == 2'd3) || in_last);
    store     = accept && !emit;
    out_drain = out_valid_q && out_ready;
  end

  // Assemble the outgoing byte: lanes below cnt come from the buffer, lane cnt
  // is the current activation, lanes above cnt stay zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    pack_byte = 8'h00;
    act_pos   = {cnt_q, 1'b0};
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < cnt_q) begin
        pack_byte[2*i +: 2] = lane_q[i];
      end
    end
    pack_byte[act_pos +: 2] = act;
  end

  // Next-state for the lane buffer and lane counter. clr drops the partial
  // byte by rewinding cnt; stale lane contents are masked by cnt on emit.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lane_d[i] = lane_q[i];
      if (store && (cnt_q == 2'(i))) begin
        lane_d[i] = act;
      end
    end
    cnt_d = cnt_q;
    if (clr || emit) begin
      cnt_d = 2'd0;
    end else if (store) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Next-state for the single-entry output register. A new emit overrides a
  // drain in the same cycle so full bytes flow back-to-back; otherwise the
  // payload holds steady while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lanes_d = out_lanes_q;
    out_last_d  = out_last_q;
    if (clr) begin
      out_valid_d = 1'b0;
    end else if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = pack_byte;
      out_lanes_d = {1'b0, cnt_q} + 3'd1;
      out_last_d  = in_last;
    end else if (out_drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Next-state for the calibration counter: counts accepted clamp events and
  // sticks at 255; clr zeroes it.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr) begin
      sat_cnt_d = 8'd0;
    end else if (accept && sat_event && (sat_cnt_q != 8'hFF)) begin
      sat_cnt_d = sat_cnt_q + 8'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the lane buffer is tiny and reset to zero so the reset state is
      // fully defined; a large storage array would normally be left unreset.
      for (int i = 0; i < 3; i++) begin
        lane_q[i] <= 2'd0;
      end
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_lanes_q <= 3'd0;
      out_last_q  <= 1'b0;
      sat_cnt_q   <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from before the edge, independent of order.
      for (int i = 0; i < 3; i++) begin
        lane_q[i] <= lane_d[i];
      end
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lanes_q <= out_lanes_d;
      out_last_q  <= out_last_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  // Registered outputs.
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lanes = out_lanes_q;
  assign out_last  = out_last_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
